// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter
//
// Purpose: shares one single-ported synchronous memory between an
// instruction-fetch port and a data (load/store) port. Each access takes
// two cycles: an ISSUE cycle that drives the memory, and a RESP cycle that
// returns data and pulses the requester's ready. Data requests normally win
// arbitration. A fairness counter lets fetch win once data has taken
// FAIR_LIMIT grants in a row while fetch was waiting.
//
// Ports:
//   clk, reset           clock and asynchronous active-low reset
//   if_req, if_addr      fetch request and word address
//   if_ready, if_rdata   fetch completion pulse and fetched word
//   d_req, d_we, d_addr, d_wdata, d_wmask
//                        data request, store flag, address, write data,
//                        byte enables
//   d_ready, d_rdata     data completion pulse and load result
//   mem_en, mem_we, mem_addr, mem_wdata, mem_wmask
//                        memory command, driven during the ISSUE cycle
//   mem_rdata            memory read data, valid the cycle after mem_en
//   stall                a request is pending and its ready is not pulsing
module mem_port_arbiter #(
  parameter int AW         = 12,
  parameter int DW         = 32,
  parameter int FAIR_LIMIT = 2
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          if_req,
  input  logic [AW-1:0] if_addr,
  output logic          if_ready,
  output logic [DW-1:0] if_rdata,
  input  logic          d_req,
  input  logic          d_we,
  input  logic [AW-1:0] d_addr,
  input  logic [DW-1:0] d_wdata,
  input  logic [3:0]    d_wmask,
  output logic          d_ready,
  output logic [DW-1:0] d_rdata,
  output logic          mem_en,
  output logic          mem_we,
  output logic [AW-1:0] mem_addr,
  output logic [DW-1:0] mem_wdata,
  output logic [3:0]    mem_wmask,
  input  logic [DW-1:0] mem_rdata,
  output logic          stall
);

  localparam int FW = (FAIR_LIMIT < 1) ? 1 : $clog2(FAIR_LIMIT + 1);
  localparam logic [FW-1:0] FAIR_MAX = FW'(FAIR_LIMIT);

  typedef enum logic [2:0] {
    IDLE     = 3'd0,
    ISSUE_IF = 3'd1,
    ISSUE_D  = 3'd2,
    RESP_IF  = 3'd3,
    RESP_D   = 3'd4
  } state_t;

  state_t        state;
  state_t        next_state;
  logic          grant_if;
  logic          grant_d;
  logic          if_elig;
  logic          d_elig;
  logic [FW-1:0] fair_cnt;
  logic          d_store;
  logic [DW-1:0] if_rdata_hold;
  logic [DW-1:0] d_rdata_hold;

  // State register.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state <= IDLE;
    end else begin
      state <= next_state;
    end
  end

  // Next-state and grant decision. A port whose ready is pulsing this cycle
  // still has its req high for the request being completed, so it must not
  // be granted again here or the access would be duplicated.
  always_comb begin
    next_state = state;
    grant_if   = 1'b0;
    grant_d    = 1'b0;
    if_elig    = if_req && (state != RESP_IF);
    d_elig     = d_req && (state != RESP_D);
    case (state)
      ISSUE_IF: next_state = RESP_IF;
      ISSUE_D:  next_state = RESP_D;
      IDLE, RESP_IF, RESP_D: begin
        if (if_elig && (!d_elig || (fair_cnt == FAIR_MAX))) begin
          grant_if   = 1'b1;
          next_state = ISSUE_IF;
        end else if (d_elig) begin
          grant_d    = 1'b1;
          next_state = ISSUE_D;
        end else begin
          next_state = IDLE;
        end
      end
      default: next_state = IDLE;
    endcase
  end

  // Fairness counter: consecutive data grants taken while fetch is waiting.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      fair_cnt <= '0;
    end else if (!if_req || grant_if) begin
      fair_cnt <= '0;
    end else if (grant_d && (fair_cnt != FAIR_MAX)) begin
      fair_cnt <= fair_cnt + {{(FW-1){1'b0}}, 1'b1};
    end else begin
      fair_cnt <= fair_cnt;
    end
  end

  // Memory command registers, loaded on the grant edge. Enables drop after
  // the ISSUE cycle; address and write data keep their last value.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      mem_en    <= 1'b0;
      mem_we    <= 1'b0;
      mem_wmask <= 4'h0;
      mem_addr  <= '0;
      mem_wdata <= '0;
      d_store   <= 1'b0;
    end else if (grant_if) begin
      mem_en    <= 1'b1;
      mem_we    <= 1'b0;
      mem_wmask <= 4'h0;
      mem_addr  <= if_addr;
    end else if (grant_d) begin
      mem_en    <= 1'b1;
      mem_we    <= d_we;
      mem_wmask <= d_wmask;
      mem_addr  <= d_addr;
      mem_wdata <= d_wdata;
      d_store   <= d_we;
    end else begin
      mem_en    <= 1'b0;
      mem_we    <= 1'b0;
      mem_wmask <= 4'h0;
    end
  end

  // Read-data holding registers, captured at the end of each read response.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      if_rdata_hold <= '0;
      d_rdata_hold  <= '0;
    end else begin
      if (state == RESP_IF) begin
        if_rdata_hold <= mem_rdata;
      end else begin
        if_rdata_hold <= if_rdata_hold;
      end
      if ((state == RESP_D) && !d_store) begin
        d_rdata_hold <= mem_rdata;
      end else begin
        d_rdata_hold <= d_rdata_hold;
      end
    end
  end

  // Response outputs: memory data passes straight through in the response
  // cycle (it only arrives then) and the held copy is shown otherwise.
  // Stall is forced low while reset is asserted.
  always_comb begin
    if_ready = 1'b0;
    d_ready  = 1'b0;
    if_rdata = if_rdata_hold;
    d_rdata  = d_rdata_hold;
    if (state == RESP_IF) begin
      if_ready = 1'b1;
      if_rdata = mem_rdata;
    end else begin
      if_ready = 1'b0;
    end
    if (state == RESP_D) begin
      d_ready = 1'b1;
      if (!d_store) begin
        d_rdata = mem_rdata;
      end else begin
        d_rdata = d_rdata_hold;
      end
    end else begin
      d_ready = 1'b0;
    end
    stall = reset & ((if_req & ~if_ready) | (d_req & ~d_ready));
  end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Self-checking bench for mem_port_arbiter: a cycle table of stimulus and
// hand-computed outputs, then directed sequences for an abandoned request,
// reset in the middle of an access, and continuous competing requests.
module tb_mem_port_arbiter;

  logic        clk;
  logic        reset;
  logic        if_req;
  logic [11:0] if_addr;
  logic        if_ready;
  logic [31:0] if_rdata;
  logic        d_req;
  logic        d_we;
  logic [11:0] d_addr;
  logic [31:0] d_wdata;
  logic [3:0]  d_wmask;
  logic        d_ready;
  logic [31:0] d_rdata;
  logic        mem_en;
  logic        mem_we;
  logic [11:0] mem_addr;
  logic [31:0] mem_wdata;
  logic [3:0]  mem_wmask;
  logic [31:0] mem_rdata;
  logic        stall;

  logic        load_mem;
  logic [31:0] mem [0:4095];

  int checks;
  int errors;

  mem_port_arbiter #(.AW(12), .DW(32), .FAIR_LIMIT(2)) dut (
    .clk       (clk),
    .reset     (reset),
    .if_req    (if_req),
    .if_addr   (if_addr),
    .if_ready  (if_ready),
    .if_rdata  (if_rdata),
    .d_req     (d_req),
    .d_we      (d_we),
    .d_addr    (d_addr),
    .d_wdata   (d_wdata),
    .d_wmask   (d_wmask),
    .d_ready   (d_ready),
    .d_rdata   (d_rdata),
    .mem_en    (mem_en),
    .mem_we    (mem_we),
    .mem_addr  (mem_addr),
    .mem_wdata (mem_wdata),
    .mem_wmask (mem_wmask),
    .mem_rdata (mem_rdata),
    .stall     (stall)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Synchronous memory: byte-masked writes, read data one cycle after mem_en.
  always @(posedge clk) begin
    if (load_mem) begin
      mem[12'h004] <= 32'h00500093;
      mem[12'h010] <= 32'h00000000;
      mem[12'h020] <= 32'h11223344;
      mem[12'h030] <= 32'hCAFEF00D;
    end else if (mem_en) begin
      if (mem_we) begin
        for (int b = 0; b < 4; b++) begin
          if (mem_wmask[b]) mem[mem_addr][8*b +: 8] <= mem_wdata[8*b +: 8];
        end
      end else begin
        mem_rdata <= mem[mem_addr];
      end
    end
  end

  typedef struct {
    logic        ifr;
    logic [11:0] ia;
    logic        dr;
    logic        dw;
    logic [11:0] da;
    logic [31:0] dd;
    logic [3:0]  dm;
    logic        e_ifr;
    logic        e_dr;
    logic        e_en;
    logic        e_we;
    logic [11:0] e_addr;
    logic [3:0]  e_mask;
    logic        e_stall;
    logic [31:0] e_ird;
    logic [31:0] e_drd;
  } vec_t;

  vec_t vq[$];

  function automatic vec_t mk(input logic ifr, input logic [11:0] ia,
                              input logic dr, input logic dw,
                              input logic [11:0] da, input logic [31:0] dd,
                              input logic [3:0] dm, input logic rif,
                              input logic rd, input logic en, input logic we,
                              input logic [11:0] addr, input logic [3:0] msk,
                              input logic st, input logic [31:0] ird,
                              input logic [31:0] drd);
    vec_t v;
    v.ifr = ifr; v.ia = ia; v.dr = dr; v.dw = dw; v.da = da; v.dd = dd;
    v.dm = dm; v.e_ifr = rif; v.e_dr = rd; v.e_en = en; v.e_we = we;
    v.e_addr = addr; v.e_mask = msk; v.e_stall = st; v.e_ird = ird;
    v.e_drd = drd;
    return v;
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h, expected %h", nm, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  localparam logic [31:0] WI = 32'h00500093;
  localparam logic [31:0] WF = 32'hCAFEF00D;
  localparam logic [31:0] WB = 32'hDEADBEEF;
  localparam logic [31:0] WM = 32'h1122AB44;

  initial begin
    vec_t v;
    int   wait_if;
    int   max_wait;
    int   n_if;
    int   n_d;
    int   first;

    checks   = 0;
    errors   = 0;
    load_mem = 1'b1;
    reset    = 1'b0;
    if_req   = 1'b1;
    if_addr  = 12'h004;
    d_req    = 1'b1;
    d_we     = 1'b1;
    d_addr   = 12'h010;
    d_wdata  = 32'h12345678;
    d_wmask  = 4'hF;

    // Requests during reset must not start anything; every output stays 0.
    repeat (3) tick();
    chk("rst mem_en",   {31'd0, mem_en},   32'd0);
    chk("rst if_ready", {31'd0, if_ready}, 32'd0);
    chk("rst d_ready",  {31'd0, d_ready},  32'd0);
    chk("rst stall",    {31'd0, stall},    32'd0);
    chk("rst mem_addr", {20'd0, mem_addr}, 32'd0);
    chk("rst if_rdata", if_rdata,          32'd0);
    chk("rst d_rdata",  d_rdata,           32'd0);

    load_mem = 1'b0;
    if_req   = 1'b0;
    d_req    = 1'b0;
    d_we     = 1'b0;
    d_wdata  = 32'd0;
    d_wmask  = 4'h0;
    @(negedge clk);
    reset = 1'b1;

    // ifr ia dr dw da dd dm | if_ready d_ready en we addr mask stall if_rdata d_rdata
    vq.push_back(mk(1'b0, 12'h000, 1'b0, 1'b0, 12'h000, 32'h0, 4'h0, 1'b0, 1'b0, 1'b0, 1'b0, 12'h000, 4'h0, 1'b0, 32'h0, 32'h0));
    vq.push_back(mk(1'b1, 12'h004, 1'b0, 1'b0, 12'h000, 32'h0, 4'h0, 1'b0, 1'b0, 1'b1, 1'b0, 12'h004, 4'h0, 1'b1, 32'h0, 32'h0));
    vq.push_back(mk(1'b1, 12'h004, 1'b0, 1'b0, 12'h000, 32'h0, 4'h0, 1'b1, 1'b0, 1'b0, 1'b0, 12'h004, 4'h0, 1'b0, WI, 32'h0));
    vq.push_back(mk(1'b0, 12'h004, 1'b0, 1'b0, 12'h000, 32'h0, 4'h0, 1'b0, 1'b0, 1'b0, 1'b0, 12'h004, 4'h0, 1'b0, WI, 32'h0));
    vq.push_back(mk(1'b0, 12'h000, 1'b1, 1'b1, 12'h010, WB, 4'hF, 1'b0, 1'b0, 1'b1, 1'b1, 12'h010, 4'hF, 1'b1, WI, 32'h0));
    vq.push_back(mk(1'b0, 12'h000, 1'b1, 1'b1, 12'h010, WB, 4'hF, 1'b0, 1'b1, 1'b0, 1'b0, 12'h010, 4'h0, 1'b0, WI, 32'h0));
    vq.push_back(mk(1'b0, 12'h000, 1'b1, 1'b0, 12'h010, 32'h0, 4'h0, 1'b0, 1'b0, 1'b0, 1'b0, 12'h010, 4'h0, 1'b1, WI, 32'h0));
    vq.push_back(mk(1'b0, 12'h000, 1'b1, 1'b0, 12'h010, 32'h0, 4'h0, 1'b0, 1'b0, 1'b1, 1'b0, 12'h010, 4'h0, 1'b1, WI, 32'h0));
    vq.push_back(mk(1'b0, 12'h000, 1'b1, 1'b0, 12'h010, 32'h0, 4'h0, 1'b0, 1'b1, 1'b0, 1'b0, 12'h010, 4'h0, 1'b0, WI, WB));
    vq.push_back(mk(1'b0, 12'h000, 1'b0, 1'b0, 12'h010, 32'h0, 4'h0, 1'b0, 1'b0, 1'b0, 1'b0, 12'h010, 4'h0, 1'b0, WI, WB));
    vq.push_back(mk(1'b0, 12'h000, 1'b1, 1'b1, 12'h020, 32'h0000AB00, 4'h2, 1'b0, 1'b0, 1'b1, 1'b1, 12'h020, 4'h2, 1'b1, WI, WB));
    vq.push_back(mk(1'b0, 12'h000, 1'b1, 1'b1, 12'h020, 32'h0000AB00, 4'h2, 1'b0, 1'b1, 1'b0, 1'b0, 12'h020, 4'h0, 1'b0, WI, WB));
    vq.push_back(mk(1'b0, 12'h000, 1'b1, 1'b0, 12'h020, 32'h0, 4'h0, 1'b0, 1'b0, 1'b0, 1'b0, 12'h020, 4'h0, 1'b1, WI, WB));
    vq.push_back(mk(1'b0, 12'h000, 1'b1, 1'b0, 12'h020, 32'h0, 4'h0, 1'b0, 1'b0, 1'b1, 1'b0, 12'h020, 4'h0, 1'b1, WI, WB));
    vq.push_back(mk(1'b0, 12'h000, 1'b1, 1'b0, 12'h020, 32'h0, 4'h0, 1'b0, 1'b1, 1'b0, 1'b0, 12'h020, 4'h0, 1'b0, WI, WM));
    vq.push_back(mk(1'b0, 12'h000, 1'b0, 1'b0, 12'h020, 32'h0, 4'h0, 1'b0, 1'b0, 1'b0, 1'b0, 12'h020, 4'h0, 1'b0, WI, WM));
    vq.push_back(mk(1'b1, 12'h030, 1'b1, 1'b0, 12'h010, 32'h0, 4'h0, 1'b0, 1'b0, 1'b1, 1'b0, 12'h010, 4'h0, 1'b1, WI, WM));
    vq.push_back(mk(1'b1, 12'h030, 1'b1, 1'b0, 12'h010, 32'h0, 4'h0, 1'b0, 1'b1, 1'b0, 1'b0, 12'h010, 4'h0, 1'b1, WI, WB));
    vq.push_back(mk(1'b1, 12'h030, 1'b0, 1'b0, 12'h010, 32'h0, 4'h0, 1'b0, 1'b0, 1'b1, 1'b0, 12'h030, 4'h0, 1'b1, WI, WB));
    vq.push_back(mk(1'b1, 12'h030, 1'b0, 1'b0, 12'h010, 32'h0, 4'h0, 1'b1, 1'b0, 1'b0, 1'b0, 12'h030, 4'h0, 1'b0, WF, WB));
    vq.push_back(mk(1'b0, 12'h030, 1'b0, 1'b0, 12'h010, 32'h0, 4'h0, 1'b0, 1'b0, 1'b0, 1'b0, 12'h030, 4'h0, 1'b0, WF, WB));

    for (int i = 0; i < vq.size(); i++) begin
      v       = vq[i];
      if_req  = v.ifr;
      if_addr = v.ia;
      d_req   = v.dr;
      d_we    = v.dw;
      d_addr  = v.da;
      d_wdata = v.dd;
      d_wmask = v.dm;
      tick();
      chk($sformatf("row%0d if_ready", i),  {31'd0, if_ready},  {31'd0, v.e_ifr});
      chk($sformatf("row%0d d_ready", i),   {31'd0, d_ready},   {31'd0, v.e_dr});
      chk($sformatf("row%0d mem_en", i),    {31'd0, mem_en},    {31'd0, v.e_en});
      chk($sformatf("row%0d mem_we", i),    {31'd0, mem_we},    {31'd0, v.e_we});
      chk($sformatf("row%0d mem_addr", i),  {20'd0, mem_addr},  {20'd0, v.e_addr});
      chk($sformatf("row%0d mem_wmask", i), {28'd0, mem_wmask}, {28'd0, v.e_mask});
      chk($sformatf("row%0d stall", i),     {31'd0, stall},     {31'd0, v.e_stall});
      chk($sformatf("row%0d if_rdata", i),  if_rdata,           v.e_ird);
      chk($sformatf("row%0d d_rdata", i),   d_rdata,            v.e_drd);
    end

    // A load whose req drops after the grant still completes.
    d_req   = 1'b1;
    d_we    = 1'b0;
    d_addr  = 12'h020;
    d_wmask = 4'h0;
    tick();
    chk("drop mem_en", {31'd0, mem_en}, 32'd1);
    d_req = 1'b0;
    tick();
    chk("drop d_ready", {31'd0, d_ready}, 32'd1);
    chk("drop d_rdata", d_rdata, WM);
    tick();
    chk("drop idle d_ready", {31'd0, d_ready}, 32'd0);

    // Reset in the ISSUE cycle of a load: outputs clear at once, no ready,
    // and the still-held request is served from scratch after release.
    d_req  = 1'b1;
    d_addr = 12'h010;
    tick();
    chk("mid mem_en", {31'd0, mem_en}, 32'd1);
    #2;
    reset = 1'b0;
    #1;
    chk("mid rst mem_en",    {31'd0, mem_en},    32'd0);
    chk("mid rst mem_addr",  {20'd0, mem_addr},  32'd0);
    chk("mid rst mem_wdata", mem_wdata,          32'd0);
    chk("mid rst d_rdata",   d_rdata,            32'd0);
    chk("mid rst if_rdata",  if_rdata,           32'd0);
    chk("mid rst stall",     {31'd0, stall},     32'd0);
    tick();
    chk("mid rst d_ready",   {31'd0, d_ready},   32'd0);
    @(negedge clk);
    reset = 1'b1;
    tick();
    chk("rel mem_en",  {31'd0, mem_en},  32'd1);
    chk("rel d_ready", {31'd0, d_ready}, 32'd0);
    tick();
    chk("rel d_ready2", {31'd0, d_ready}, 32'd1);
    chk("rel d_rdata",  d_rdata,          WB);
    d_req = 1'b0;
    tick();

    // Continuous fetch and data loads from IDLE.
    if_req   = 1'b1;
    if_addr  = 12'h030;
    d_req    = 1'b1;
    d_addr   = 12'h010;
    wait_if  = 0;
    max_wait = 0;
    n_if     = 0;
    n_d      = 0;
    first    = 0;
    for (int c = 0; c < 24; c++) begin
      tick();
      chk($sformatf("cont c%0d both ready", c), {31'd0, if_ready & d_ready}, 32'd0);
      if (if_ready) begin
        chk($sformatf("cont c%0d if_rdata", c), if_rdata, WF);
        n_if++;
        wait_if = 0;
        if (first == 0) first = 1;
      end else begin
        wait_if++;
      end
      if (d_ready) begin
        chk($sformatf("cont c%0d d_rdata", c), d_rdata, WB);
        n_d++;
        if (first == 0) first = 2;
      end
      if (wait_if > max_wait) max_wait = wait_if;
    end
    chk("cont first is data", first, 2);
    chk("cont fetch wait<=6", {31'd0, (max_wait <= 6)}, 32'd1);
    chk("cont throughput", n_if + n_d, 12);
    chk("cont fetch served", {31'd0, (n_if >= 4)}, 32'd1);
    chk("cont data served",  {31'd0, (n_d >= 4)},  32'd1);
    if_req = 1'b0;
    d_req  = 1'b0;
    repeat (3) tick();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
